// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: issues one command at a time to a fixed-latency logic unit and returns its result with flags
module logic_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int LU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [2:0]       lu_op,
  input  logic [WIDTH-1:0] lu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_parity,
  output logic             rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT = LU_LATENCY[3:0];
  state_t state, state_nx;
  logic [3:0] cnt;
  logic accept, illegal;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept = cmd_valid & cmd_ready;
  assign illegal = cmd_op[2] & cmd_op[1];
  assign rsp_zero = rsp_data == '0;
  assign rsp_parity = ^rsp_data;
  always_comb begin
    state_nx = state;
    state_nx = accept ? (illegal ? RESP : WAIT) :
               (state == WAIT && cnt == 4'd0) ? RESP :
               (state == RESP && rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // Operand registers only move on a legal accept, so the unit sees stable inputs until the next command
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lu_a <= '0;
      lu_b <= '0;
      lu_op <= '0;
      cnt <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else if (accept && illegal) begin
      rsp_data <= '0;
      rsp_err <= 1'b1;
    end else if (accept) begin
      lu_a <= cmd_a;
      lu_b <= cmd_b;
      lu_op <= cmd_op;
      cnt <= LAT;
    end else if (state == WAIT) begin
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
      else begin
        rsp_data <= lu_result;
        rsp_err <= 1'b0;
      end
    end
endmodule

// File: tb/tb_logic_op_sequencer.sv
// tb_logic_op_sequencer: three sequencer builds (latency 1, 4, 0) each paired with a delayed logic-unit model
module tb_logic_op_sequencer;
  localparam logic [11:0] LATS = {4'd0, 4'd4, 4'd1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] cmd_valid_v = '0, rsp_ready_v = '0;
  logic [2:0] cmd_ready_v, rsp_valid_v, rsp_zero_v, rsp_parity_v, rsp_err_v;
  logic [2:0] cmd_op = '0;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic [15:0] lu_a_v [3], lu_b_v [3], lu_res_v [3], rsp_data_v [3];
  logic [2:0] lu_op_v [3];
  logic [15:0] exp_lu_a [3], exp_lu_b [3];
  logic [2:0] exp_lu_op [3];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] op_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: op_fn = a | b;
      3'd1: op_fn = ~(a | b);
      3'd2: op_fn = a ^ b;
      3'd3: op_fn = ~(a ^ b);
      3'd4: op_fn = a & b;
      3'd5: op_fn = ~(a & b);
      default: op_fn = 16'hDEAD;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int L = int'(LATS[g*4 +: 4]);
    logic_op_sequencer #(.WIDTH(16), .LU_LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid_v[g]), .cmd_ready(cmd_ready_v[g]),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .lu_a(lu_a_v[g]), .lu_b(lu_b_v[g]), .lu_op(lu_op_v[g]), .lu_result(lu_res_v[g]),
      .rsp_valid(rsp_valid_v[g]), .rsp_ready(rsp_ready_v[g]),
      .rsp_data(rsp_data_v[g]), .rsp_zero(rsp_zero_v[g]),
      .rsp_parity(rsp_parity_v[g]), .rsp_err(rsp_err_v[g])
    );
    if (L == 0) begin : c
      assign lu_res_v[g] = op_fn(lu_op_v[g], lu_a_v[g], lu_b_v[g]);
    end else begin : s
      logic [15:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= op_fn(lu_op_v[g], lu_a_v[g], lu_b_v[g]);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign lu_res_v[g] = pipe[L-1];
    end
  end

  function automatic int exp_lat(input int d, input logic [2:0] op);
    exp_lat = (op[2:1] == 2'b11) ? 0 : int'(LATS[d*4 +: 4]) + 1;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      exp_lu_a[i] = '0;
      exp_lu_b[i] = '0;
      exp_lu_op[i] = '0;
    end
  endtask

  // lat = clock edges after the accept edge until rsp_valid is seen (-1 on timeout)
  task automatic do_cmd(input int d, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold, output int lat, output logic [15:0] data, output logic [2:0] f, output int bad);
    bad = 0;
    @(negedge clk);
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_valid_v[d] = 1'b1;
    if (!cmd_ready_v[d]) bad++;
    @(posedge clk);
    if (op[2:1] != 2'b11) begin
      exp_lu_a[d] = a;
      exp_lu_b[d] = b;
      exp_lu_op[d] = op;
    end
    @(negedge clk);
    lat = 0;
    cmd_op = 3'($urandom);
    cmd_a = 16'($urandom);
    cmd_b = 16'($urandom);
    while (!rsp_valid_v[d] && lat < 40) begin
      if (cmd_ready_v[d]) bad++;
      @(posedge clk);
      @(negedge clk);
      lat++;
      cmd_op = 3'($urandom);
      cmd_a = 16'($urandom);
    end
    cmd_valid_v[d] = 1'b0;
    if (!rsp_valid_v[d]) begin
      lat = -1;
      data = 'x;
      f = 'x;
      return;
    end
    data = rsp_data_v[d];
    f = {rsp_zero_v[d], rsp_parity_v[d], rsp_err_v[d]};
    if (cmd_ready_v[d]) bad++;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid_v[d] || cmd_ready_v[d] || rsp_data_v[d] !== data ||
          {rsp_zero_v[d], rsp_parity_v[d], rsp_err_v[d]} !== f) bad++;
    end
    rsp_ready_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({cmd_ready_v[d], rsp_valid_v[d], rsp_zero_v[d], rsp_parity_v[d], rsp_err_v[d]} !== 5'b10100) begin
        failures++;
        $display("FAIL reset_ctl d=%0d got=%b exp=10100", d, {cmd_ready_v[d], rsp_valid_v[d], rsp_zero_v[d], rsp_parity_v[d], rsp_err_v[d]});
      end
      checks++;
      if ({lu_a_v[d], lu_b_v[d], lu_op_v[d], rsp_data_v[d]} !== 51'd0) begin
        failures++;
        $display("FAIL reset_data d=%0d lu_a=%h lu_b=%h lu_op=%b rsp_data=%h exp all 0", d, lu_a_v[d], lu_b_v[d], lu_op_v[d], rsp_data_v[d]);
      end
    end
  endtask

  task automatic test_directed();
    int lat, bad;
    logic [15:0] data;
    logic [2:0] f;
    do_cmd(0, 3'b010, 16'hF0F0, 16'hFF00, 0, lat, data, f, bad);
    checks++;
    if (lat !== 2 || data !== 16'h0FF0 || f !== 3'b000) begin
      failures++;
      $display("FAIL xor lat=%0d data=%h zpe=%b exp lat=2 data=0ff0 zpe=000", lat, data, f);
    end
    checks++;
    if (lu_op_v[0] !== 3'b010 || lu_a_v[0] !== 16'hF0F0 || lu_b_v[0] !== 16'hFF00) begin
      failures++;
      $display("FAIL xor_lu op=%b a=%h b=%h exp 010 f0f0 ff00", lu_op_v[0], lu_a_v[0], lu_b_v[0]);
    end
    do_cmd(0, 3'b001, 16'hFFFF, 16'h0000, 0, lat, data, f, bad);
    checks++;
    if (data !== 16'h0000 || f !== 3'b100) begin
      failures++;
      $display("FAIL nor_zero data=%h zpe=%b exp 0000 100", data, f);
    end
    do_cmd(0, 3'b000, 16'h0001, 16'h0000, 0, lat, data, f, bad);
    checks++;
    if (data !== 16'h0001 || f !== 3'b010) begin
      failures++;
      $display("FAIL or_parity data=%h zpe=%b exp 0001 010", data, f);
    end
  endtask

  task automatic test_illegal();
    int lat, bad;
    logic [15:0] data;
    logic [2:0] f;
    for (int k = 6; k < 8; k++) begin
      do_cmd(0, 3'(k), 16'h1234, 16'h5678, 0, lat, data, f, bad);
      checks++;
      if (lat !== 0 || data !== 16'h0000 || f !== 3'b101) begin
        failures++;
        $display("FAIL illegal op=%0d lat=%0d data=%h zpe=%b exp lat=0 data=0000 zpe=101", k, lat, data, f);
      end
      checks++;
      if (lu_op_v[0] !== 3'b000 || lu_a_v[0] !== 16'h0001 || lu_b_v[0] !== 16'h0000) begin
        failures++;
        $display("FAIL illegal_lu_hold op=%b a=%h b=%h exp 000 0001 0000", lu_op_v[0], lu_a_v[0], lu_b_v[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, bad;
    logic [15:0] data;
    logic [2:0] f;
    do_cmd(0, 3'b101, 16'hAAAA, 16'h0F0F, 5, lat, data, f, bad);
    checks++;
    if (bad !== 0 || data !== 16'hF5F5) begin
      failures++;
      $display("FAIL backpressure unstable_cycles=%0d data=%h exp 0 f5f5", bad, data);
    end
    checks++;
    if (cmd_ready_v[0] !== 1'b1 || rsp_valid_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_release cmd_ready=%b rsp_valid=%b exp 1 0", cmd_ready_v[0], rsp_valid_v[0]);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat, bad, seen;
    logic [15:0] data;
    logic [2:0] f;
    @(negedge clk);
    cmd_op = 3'b100;
    cmd_a = 16'hBEEF;
    cmd_b = 16'hFFFF;
    cmd_valid_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid_v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid_v !== 3'b000 || cmd_ready_v !== 3'b111 || lu_a_v[1] !== 16'h0 || lu_op_v[1] !== 3'b0 ||
        rsp_data_v[1] !== 16'h0 || rsp_zero_v[1] !== 1'b1) begin
      failures++;
      $display("FAIL async_reset rsp_valid=%b cmd_ready=%b lu_a=%h lu_op=%b data=%h zero=%b exp 000 111 0000 000 0000 1",
               rsp_valid_v, cmd_ready_v, lu_a_v[1], lu_op_v[1], rsp_data_v[1], rsp_zero_v[1]);
    end
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid_v[1]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL dropped_cmd rsp_valid_cycles=%0d exp 0", seen);
    end
    do_cmd(1, 3'b011, 16'h00FF, 16'h0F0F, 1, lat, data, f, bad);
    checks++;
    if (lat !== 5 || data !== 16'hF00F || f !== 3'b000 || bad !== 0) begin
      failures++;
      $display("FAIL post_reset lat=%0d data=%h zpe=%b bad=%0d exp 5 f00f 000 0", lat, data, f, bad);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    logic [15:0] data;
    logic [2:0] f;
    do_cmd(2, 3'b100, 16'h00FF, 16'h0F0F, 0, lat, data, f, bad);
    checks++;
    if (lat !== 1 || data !== 16'h000F || f !== 3'b000) begin
      failures++;
      $display("FAIL lat0_and lat=%0d data=%h zpe=%b exp 1 000f 000", lat, data, f);
    end
    do_cmd(2, 3'b101, 16'h00FF, 16'h0F0F, 0, lat, data, f, bad);
    checks++;
    if (lat !== 1 || data !== 16'hFFF0 || f !== 3'b000) begin
      failures++;
      $display("FAIL lat0_nand lat=%0d data=%h zpe=%b exp 1 fff0 000", lat, data, f);
    end
  endtask

  task automatic test_random();
    int lat, bad, d, hold, el;
    logic [2:0] op, ef;
    logic [15:0] a, b, data, ed;
    logic [2:0] f;
    for (int n = 0; n < 60; n++) begin
      d = $urandom_range(0, 2);
      op = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      b = 16'($urandom);
      if (n % 7 == 0) b = ~a;
      hold = $urandom_range(0, 2);
      ed = (op[2:1] == 2'b11) ? 16'h0 : op_fn(op, a, b);
      ef = {ed == 16'h0, ^ed, op[2:1] == 2'b11};
      el = exp_lat(d, op);
      do_cmd(d, op, a, b, hold, lat, data, f, bad);
      checks++;
      if (lat !== el || data !== ed || f !== ef || bad !== 0) begin
        failures++;
        $display("FAIL rand n=%0d d=%0d op=%b lat=%0d data=%h zpe=%b bad=%0d exp lat=%0d data=%h zpe=%b bad=0",
                 n, d, op, lat, data, f, bad, el, ed, ef);
      end
      checks++;
      if (lu_a_v[d] !== exp_lu_a[d] || lu_b_v[d] !== exp_lu_b[d] || lu_op_v[d] !== exp_lu_op[d] || cmd_ready_v[d] !== 1'b1) begin
        failures++;
        $display("FAIL rand_lu n=%0d d=%0d a=%h b=%h op=%b ready=%b exp %h %h %b 1",
                 n, d, lu_a_v[d], lu_b_v[d], lu_op_v[d], cmd_ready_v[d], exp_lu_a[d], exp_lu_b[d], exp_lu_op[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
